// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared encodings for the memory-access stage.
//   - memory op codes carried on mem_op_i (MEM_NOP .. MEM_SW)
//   - LSU FSM state encoding
//   - common zero constants used by the writeback path
//   - small decode helpers (memory op / store / natural alignment)
package mem_lsu_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;

  localparam logic [31:0] ZERO          = '0;
  localparam logic [4:0]  ZERO_REG      = '0;
  localparam logic        WRITE_DISABLE = 1'b0;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LH  = 4'd2,
    MEM_LW  = 4'd3,
    MEM_LBU = 4'd4,
    MEM_LHU = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  // Codes 9..15 are not memory ops and are passed through like MEM_NOP.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op != MEM_NOP) && (op <= MEM_SW);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lo);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: return lo[0];
      MEM_LW, MEM_SW:          return lo != 2'b00;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// lsu_align: purely combinational lane logic for the LSU.
//   op         : memory op code
//   addr_lo    : byte address bits [1:0]
//   store_data : right-justified store data
//   rdata      : raw bus read word
//   be         : byte enables for the access
//   wdata      : store data replicated across byte lanes
//   load_data  : extracted and sign/zero-extended load result
// Halfwords look only at addr_lo[1] and words at neither, so naturally
// masked alignment falls out without extra logic.
module lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      MEM_LH, MEM_LHU, MEM_SH: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (op)
      MEM_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: load_data = {24'h0, byte_sel};
      MEM_LH:  load_data = {{16{half_sel[15]}}, half_sel};
      MEM_LHU: load_data = {16'h0, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: memory-access stage after the exe/mem register.
// Runs loads/stores on a req/gnt/rvalid data bus, stalls the pipe until the
// access completes, and forwards non-memory results to writeback unchanged.
//   clk_i, rst_n_i                 : clock, async active-low reset
//   mem_we_i/addr_i/data_i/op_i    : request from exe_mem
//   reg_waddr_i/we_i/wdata_i       : writeback fields from exe_mem
//   bus_req/we/addr/be/wdata_o     : data bus request side
//   bus_gnt_i/rvalid_i/rdata_i     : data bus response side
//   reg_waddr/we/wdata_o           : to writeback
//   stallreq_o                     : stall request to pipe_ctrl
//   misaligned_o                   : misaligned-access pulse
// Build option: MISALIGN_TRAP_EN makes misaligned accesses skip the bus and
// pulse misaligned_o; otherwise low address bits are masked.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_WIDTH,
  parameter int unsigned DATA_W = DATA_WIDTH
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic [3:0]        mem_op_i,
  input  logic [4:0]        reg_waddr_i,
  input  logic              reg_we_i,
  input  logic [DATA_W-1:0] reg_wdata_i,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic [4:0]        reg_waddr_o,
  output logic              reg_we_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic              stallreq_o,
  output logic              misaligned_o
);

  lsu_state_e        state_q, state_d;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [4:0]        waddr_q;
  logic              we_q;
  logic [DATA_W-1:0] ldata_q;
  logic              mis_q;
  logic              mis_now;
  logic              accept;

  logic [3:0]        al_be;
  logic [DATA_W-1:0] al_wdata;
  logic [DATA_W-1:0] al_load;

  // mem_we_i is redundant with the op code; the store decode uses the op.
  logic              unused_we;
  assign unused_we = mem_we_i;

  assign accept = (state_q == ST_IDLE) && is_mem_op(mem_op_i);

`ifdef MISALIGN_TRAP_EN
  assign mis_now = is_misaligned(mem_op_i, mem_addr_i[1:0]);
`else
  assign mis_now = 1'b0;
`endif

  lsu_align u_align (
    .op         (op_q),
    .addr_lo    (addr_q[1:0]),
    .store_data (data_q),
    .rdata      (bus_rdata_i),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = mis_now ? ST_DONE : ST_REQ;
      ST_REQ:  if (bus_gnt_i) state_d = ST_WAIT;
      ST_WAIT: if (bus_rvalid_i) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      op_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      waddr_q <= '0;
      we_q    <= 1'b0;
      ldata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= mem_op_i;
        addr_q  <= mem_addr_i;
        data_q  <= mem_data_i;
        waddr_q <= reg_waddr_i;
        we_q    <= reg_we_i;
        mis_q   <= mis_now;
      end
      if ((state_q == ST_WAIT) && bus_rvalid_i && !is_store(op_q))
        ldata_q <= al_load;
    end
  end

  // Gated by rst_n_i so the combinational pass-through/stall paths also read
  // zero while reset is held.
  always_comb begin
    bus_req_o    = 1'b0;
    bus_we_o     = 1'b0;
    bus_addr_o   = '0;
    bus_be_o     = '0;
    bus_wdata_o  = '0;
    reg_waddr_o  = ZERO_REG;
    reg_we_o     = WRITE_DISABLE;
    reg_wdata_o  = ZERO;
    stallreq_o   = 1'b0;
    misaligned_o = 1'b0;
    if (rst_n_i) begin
      case (state_q)
        ST_IDLE: begin
          if (is_mem_op(mem_op_i)) begin
            stallreq_o = 1'b1;
          end else begin
            reg_waddr_o = reg_waddr_i;
            reg_we_o    = reg_we_i;
            reg_wdata_o = reg_wdata_i;
          end
        end
        ST_REQ: begin
          stallreq_o  = 1'b1;
          bus_req_o   = 1'b1;
          bus_we_o    = is_store(op_q);
          bus_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
          bus_be_o    = al_be;
          bus_wdata_o = al_wdata;
        end
        ST_WAIT: stallreq_o = 1'b1;
        ST_DONE: begin
          if (!is_store(op_q) && !mis_q) begin
            reg_we_o    = we_q;
            reg_waddr_o = waddr_q;
            reg_wdata_o = ldata_q;
          end
`ifdef MISALIGN_TRAP_EN
          misaligned_o = mis_q;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed, table-driven bench for mem_lsu, plus hand-written
// sequences for pass-through, reset mid-access and misaligned accesses.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk_i, rst_n_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i, mem_data_i;
  logic [3:0]  mem_op_i;
  logic [4:0]  reg_waddr_i;
  logic        reg_we_i;
  logic [31:0] reg_wdata_i;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i, bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic [4:0]  reg_waddr_o;
  logic        reg_we_o;
  logic [31:0] reg_wdata_o;
  logic        stallreq_o, misaligned_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  mem_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_op_i(mem_op_i),
    .reg_waddr_i(reg_waddr_i), .reg_we_i(reg_we_i), .reg_wdata_i(reg_wdata_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
    .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o), .reg_wdata_o(reg_wdata_o),
    .stallreq_o(stallreq_o), .misaligned_o(misaligned_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    int unsigned gnt_delay;
    logic [4:0]  waddr;
    logic        reg_we_in;
    logic        exp_bus_we;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_reg_we;
    logic [31:0] exp_reg_wdata;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    mem_op_i = MEM_NOP; mem_we_i = 1'b0; mem_addr_i = '0; mem_data_i = '0;
    reg_waddr_i = '0; reg_we_i = 1'b0; reg_wdata_i = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bus_req"},   32'(bus_req_o),    32'h0);
    check({tag, "_bus_we"},    32'(bus_we_o),     32'h0);
    check({tag, "_bus_addr"},  bus_addr_o,        32'h0);
    check({tag, "_bus_be"},    32'(bus_be_o),     32'h0);
    check({tag, "_bus_wdata"}, bus_wdata_o,       32'h0);
    check({tag, "_reg_waddr"}, 32'(reg_waddr_o),  32'h0);
    check({tag, "_reg_we"},    32'(reg_we_o),     32'h0);
    check({tag, "_reg_wdata"}, reg_wdata_o,       32'h0);
    check({tag, "_stall"},     32'(stallreq_o),   32'h0);
    check({tag, "_misalign"},  32'(misaligned_o), 32'h0);
  endtask

  // Entered and left #1 after a rising edge.
  task automatic run_vec(input vec_t v, input string tag);
    int unsigned stall_cnt;
    stall_cnt = 0;
    mem_op_i = v.op; mem_we_i = v.exp_bus_we; mem_addr_i = v.addr; mem_data_i = v.data;
    reg_waddr_i = v.waddr; reg_we_i = v.reg_we_in; reg_wdata_i = 32'h5A5A_5A5A;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
    #1;
    stall_cnt += stallreq_o;
    check({tag, "_idle_reg_we"}, 32'(reg_we_o), 32'h0);
    check({tag, "_idle_req"},    32'(bus_req_o), 32'h0);
    @(posedge clk_i); #1;
    for (int unsigned i = 0; i <= v.gnt_delay; i++) begin
      stall_cnt += stallreq_o;
      check({tag, "_req"},   32'(bus_req_o), 32'h1);
      check({tag, "_we"},    32'(bus_we_o),  32'(v.exp_bus_we));
      check({tag, "_addr"},  bus_addr_o,     v.exp_addr);
      check({tag, "_be"},    32'(bus_be_o),  32'(v.exp_be));
      check({tag, "_wdata"}, bus_wdata_o,    v.exp_wdata);
      if (i == v.gnt_delay) bus_gnt_i = 1'b1;
      @(posedge clk_i); #1;
    end
    bus_gnt_i = 1'b0;
    stall_cnt += stallreq_o;
    check({tag, "_wait_req"}, 32'(bus_req_o), 32'h0);
    bus_rvalid_i = 1'b1; bus_rdata_i = v.rdata;
    @(posedge clk_i); #1;
    bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0BAD_0BAD;
    check({tag, "_done_stall"},  32'(stallreq_o), 32'h0);
    check({tag, "_done_req"},    32'(bus_req_o),  32'h0);
    check({tag, "_done_reg_we"}, 32'(reg_we_o),   32'(v.exp_reg_we));
    if (v.exp_reg_we) begin
      check({tag, "_done_wdata"}, reg_wdata_o,      v.exp_reg_wdata);
      check({tag, "_done_waddr"}, 32'(reg_waddr_o), 32'(v.waddr));
    end
    check({tag, "_stall_cycles"}, stall_cnt, 3 + v.gnt_delay);
    @(posedge clk_i); #1;
    drive_idle();
  endtask

  initial begin
    //            op       addr          data          rdata         dly waddr we  bwe  exp_addr      be       exp_wdata     rwe exp_reg_wdata
    vecs[0] = '{MEM_LW,  32'h0000_0104, 32'h0,        32'hDEAD_BEEF, 0, 5'd3,  1, 0, 32'h0000_0104, 4'b1111, 32'h0000_0000, 1, 32'hDEAD_BEEF};
    vecs[1] = '{MEM_LB,  32'h0000_0103, 32'h0,        32'h80FF_FFFF, 0, 5'd4,  1, 0, 32'h0000_0100, 4'b1000, 32'h0000_0000, 1, 32'hFFFF_FF80};
    vecs[2] = '{MEM_LBU, 32'h0000_0103, 32'h0,        32'h80FF_FFFF, 1, 5'd5,  1, 0, 32'h0000_0100, 4'b1000, 32'h0000_0000, 1, 32'h0000_0080};
    vecs[3] = '{MEM_SH,  32'h0000_0202, 32'h1234_ABCD, 32'h0,        3, 5'd6,  1, 1, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 0, 32'h0};
    vecs[4] = '{MEM_LH,  32'h0000_0202, 32'h0,        32'h8001_7FFF, 0, 5'd7,  1, 0, 32'h0000_0200, 4'b1100, 32'h0000_0000, 1, 32'hFFFF_8001};
    vecs[5] = '{MEM_LHU, 32'h0000_0200, 32'h0,        32'h8001_F00F, 1, 5'd8,  1, 0, 32'h0000_0200, 4'b0011, 32'h0000_0000, 1, 32'h0000_F00F};
    vecs[6] = '{MEM_SB,  32'h0000_0301, 32'h0000_00A5, 32'h0,        2, 5'd9,  1, 1, 32'h0000_0300, 4'b0010, 32'hA5A5_A5A5, 0, 32'h0};
    vecs[7] = '{MEM_SW,  32'h0000_0400, 32'hCAFE_F00D, 32'h0,        0, 5'd10, 1, 1, 32'h0000_0400, 4'b1111, 32'hCAFE_F00D, 0, 32'h0};
    vecs[8] = '{MEM_LB,  32'h0000_0100, 32'h0,        32'h1234_567F, 0, 5'd11, 0, 0, 32'h0000_0100, 4'b0001, 32'h0000_0000, 0, 32'h0};

    rst_n_i = 1'b0;
    drive_idle();
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    // A load presented while in reset must not show through.
    mem_op_i = MEM_LW; mem_addr_i = 32'h104; reg_we_i = 1'b1; reg_wdata_i = 32'h77;
    repeat (2) @(posedge clk_i);
    #1;
    check_all_zero("reset");
    drive_idle();
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Non-memory op: same-cycle pass-through.
    mem_op_i = MEM_NOP; reg_waddr_i = 5'd5; reg_we_i = 1'b1; reg_wdata_i = 32'd7;
    #1;
    check("nop_waddr", 32'(reg_waddr_o), 32'd5);
    check("nop_we",    32'(reg_we_o),    32'd1);
    check("nop_wdata", reg_wdata_o,      32'd7);
    check("nop_stall", 32'(stallreq_o),  32'd0);
    check("nop_req",   32'(bus_req_o),   32'd0);
    reg_waddr_i = 5'd17; reg_wdata_i = 32'h1234_5678;
    #1;
    check("nop2_waddr", 32'(reg_waddr_o), 32'd17);
    check("nop2_wdata", reg_wdata_o,      32'h1234_5678);
    @(posedge clk_i); #1;
    check("nop_next_req", 32'(bus_req_o), 32'd0);
    drive_idle();

    // Reset while waiting for rvalid; the late rvalid must be ignored.
    mem_op_i = MEM_LW; mem_addr_i = 32'h104; reg_waddr_i = 5'd12; reg_we_i = 1'b1;
    @(posedge clk_i); #1;
    check("rst_seq_req", 32'(bus_req_o), 32'd1);
    bus_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    bus_gnt_i = 1'b0;
    check("rst_seq_wait_stall", 32'(stallreq_o), 32'd1);
    rst_n_i = 1'b0;
    #1;
    check_all_zero("rst_mid");
    drive_idle();
    #1;
    rst_n_i = 1'b1;
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
    @(posedge clk_i); #1;
    bus_rvalid_i = 1'b0;
    check_all_zero("rst_late_rvalid");
    @(posedge clk_i); #1;
    check_all_zero("rst_after");

`ifdef MISALIGN_TRAP_EN
    mem_op_i = MEM_LW; mem_addr_i = 32'h101; reg_waddr_i = 5'd13; reg_we_i = 1'b1;
    #1;
    check("mis_idle_stall", 32'(stallreq_o), 32'd1);
    check("mis_idle_req",   32'(bus_req_o),  32'd0);
    @(posedge clk_i); #1;
    check("mis_pulse",  32'(misaligned_o), 32'd1);
    check("mis_req",    32'(bus_req_o),    32'd0);
    check("mis_reg_we", 32'(reg_we_o),     32'd0);
    check("mis_stall",  32'(stallreq_o),   32'd0);
    @(posedge clk_i); #1;
    drive_idle();
    #1;
    check("mis_pulse_end", 32'(misaligned_o), 32'd0);
    check("mis_end_req",   32'(bus_req_o),    32'd0);
    @(posedge clk_i); #1;
`else
    begin
      vec_t m;
      m = '{MEM_LW, 32'h0000_0101, 32'h0, 32'h1122_3344, 0, 5'd13, 1, 0,
            32'h0000_0100, 4'b1111, 32'h0, 1, 32'h1122_3344};
      run_vec(m, "mis_lw");
      m = '{MEM_SH, 32'h0000_0203, 32'h0000_BEEF, 32'h0, 1, 5'd14, 1, 1,
            32'h0000_0200, 4'b1100, 32'hBEEF_BEEF, 0, 32'h0};
      run_vec(m, "mis_sh");
      check("mis_tied", 32'(misaligned_o), 32'd0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
